// File: rtl/main_nios2_qsys_0_oci_dct_pkg.sv
// Shared constants, types and the slot-insert helper for the OCI DCT packer.
package main_nios2_qsys_0_oci_dct_pkg;

  localparam int unsigned DCT_SYM_W      = 2;
  localparam int unsigned DCT_DEPTH      = 15;
  localparam int unsigned DCT_BUF_W      = DCT_SYM_W * DCT_DEPTH;
  localparam int unsigned DCT_CNT_W      = 4;
  localparam int unsigned DCT_DROP_CNT_W = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } dct_state_t;

  typedef logic [DCT_BUF_W-1:0] dct_buf_t;
  typedef logic [DCT_CNT_W-1:0] dct_cnt_t;
  typedef logic [DCT_SYM_W-1:0] dct_sym_t;

  // Frame payload handed to the trace memory writer
  typedef struct packed {
    dct_buf_t data;
    dct_cnt_t count;
  } dct_frame_t;

  // Write one symbol into the given slot of a packing buffer
  function automatic dct_buf_t dct_insert(dct_buf_t b, dct_cnt_t slot, dct_sym_t s);
    dct_buf_t r;
    r = b;
    for (int unsigned i = 0; i < DCT_DEPTH; i++) begin
      if (slot == DCT_CNT_W'(i)) r[i*DCT_SYM_W +: DCT_SYM_W] = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/main_nios2_qsys_0_oci_dct_frame_reg.sv
// One-entry valid/ready frame register between the packer and the trace writer.
module main_nios2_qsys_0_oci_dct_frame_reg
  import main_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  dct_frame_t frame_in,
  input  logic       ready,
  output logic       valid,
  output dct_frame_t frame_out,
  output logic       slot_free
);

  // A held frame that drains this cycle frees the slot for a same-cycle refill
  assign slot_free = !valid || ready;

  // Capture on load, hold while stalled, clear once consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      frame_out <= '0;
    end else if (load) begin
      valid     <= 1'b1;
      frame_out <= frame_in;
    end else if (valid && ready) begin
      valid     <= 1'b0;
      frame_out <= '0;
    end
  end

endmodule

// File: rtl/main_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace symbols into 30-bit DCT frames; drops symbols when no storage is free.
// Optional saturating drop counter enabled by defining OCI_DCT_DROP_CNT_EN.
module main_nios2_qsys_0_oci_dct_packer
  import main_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sym_valid,
  input  logic [DCT_SYM_W-1:0]      sym,
  input  logic                      flush,
  output logic [DCT_BUF_W-1:0]      dct_buffer,
  output logic [DCT_CNT_W-1:0]      dct_count,
  output logic                      frame_valid,
  input  logic                      frame_ready,
  output logic [DCT_BUF_W-1:0]      frame_data,
  output logic [DCT_CNT_W-1:0]      frame_count,
  output logic                      overflow,
  output logic                      idle,
  output logic [DCT_DROP_CNT_W-1:0] drop_count
);

  dct_state_t state_q, state_n;
  dct_buf_t   buf_q, buf_n, fill_buf;
  dct_cnt_t   cnt_q, cnt_n, fill_cnt;
  logic       pend_q, pend_n;
  logic       ovf_q, ovf_n;
  logic       idle_q, idle_n;
  logic       close;
  logic       load;
  logic       drop;
  logic       slot_free;
  dct_frame_t load_frame;
  dct_frame_t frame_q;

  main_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .frame_in  (load_frame),
    .ready     (frame_ready),
    .valid     (frame_valid),
    .frame_out (frame_q),
    .slot_free (slot_free)
  );

  // Packing state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      pend_q  <= pend_n;
      ovf_q   <= ovf_n;
      idle_q  <= idle_n;
    end
  end

  // Next-state: fill, close into the frame slot, or hold until the slot frees
  always_comb begin
    state_n    = state_q;
    buf_n      = buf_q;
    cnt_n      = cnt_q;
    pend_n     = pend_q;
    ovf_n      = ovf_q;
    load       = 1'b0;
    load_frame = '0;
    drop       = 1'b0;
    close      = 1'b0;
    fill_buf   = sym_valid ? dct_insert(buf_q, cnt_q, sym) : buf_q;
    fill_cnt   = cnt_q + DCT_CNT_W'(sym_valid);

    unique case (state_q)
      FILL: begin
        close = (fill_cnt == DCT_CNT_W'(DCT_DEPTH)) || (flush && (fill_cnt != '0));
        if (close && slot_free) begin
          load       = 1'b1;
          load_frame = '{data: fill_buf, count: fill_cnt};
          buf_n      = '0;
          cnt_n      = '0;
          pend_n     = 1'b0;
        end else if (close) begin
          // Slot busy: keep the closed frame; a short one is marked as flushed
          buf_n   = fill_buf;
          cnt_n   = fill_cnt;
          pend_n  = (fill_cnt != DCT_CNT_W'(DCT_DEPTH));
          state_n = HOLD;
        end else begin
          buf_n = fill_buf;
          cnt_n = fill_cnt;
        end
      end
      HOLD: begin
        // Symbols are dropped here, including in the transfer cycle, to keep order
        drop = sym_valid;
        if (drop) ovf_n = 1'b1;
        if (slot_free) begin
          load       = 1'b1;
          load_frame = '{data: buf_q, count: cnt_q};
          buf_n      = '0;
          cnt_n      = '0;
          pend_n     = 1'b0;
          state_n    = FILL;
        end
      end
      default: state_n = FILL;
    endcase

    idle_n = (cnt_n == '0) && !pend_n && !(load || (frame_valid && !frame_ready));
  end

  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;
  assign frame_data  = frame_q.data;
  assign frame_count = frame_q.count;
  assign overflow    = ovf_q;
  assign idle        = idle_q;

`ifdef OCI_DCT_DROP_CNT_EN
  logic [DCT_DROP_CNT_W-1:0] drop_cnt_q;

  // Saturating count of dropped symbols, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DCT_DROP_CNT_W'(1);
    end
  end

  assign drop_count = drop_cnt_q;
`else
  logic unused_drop;

  assign unused_drop = drop;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_main_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI DCT packer: table vectors, directed sequences, scoreboard.
module tb_main_nios2_qsys_0_oci_dct_packer;
  import main_nios2_qsys_0_oci_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        overflow;
  logic        idle;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  main_nios2_qsys_0_oci_dct_packer dut (
    .clk         (clk),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym         (sym),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .overflow    (overflow),
    .idle        (idle),
    .drop_count  (drop_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [29:0] data;
    int          cnt;
  } exp_frm_t;
  exp_frm_t sb_q[$];

  // Reference model: symbol list, hold flag, frame-slot occupancy
  logic [1:0] m_sym[15];
  int         m_cnt;
  bit         m_hold, m_fv, m_ovf;
  int         m_drop;

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic        f;
    logic        r;
    logic [3:0]  exp_cnt;
    logic        exp_fv;
    logic [29:0] exp_data;
    logic        exp_idle;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] m_pack();
    logic [29:0] d;
    d = '0;
    for (int i = 0; i < m_cnt; i++) d[2*i +: 2] = m_sym[i];
    return d;
  endfunction

  function automatic int exp_drop();
`ifdef OCI_DCT_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_hold = 0;
    m_fv   = 0;
    m_ovf  = 0;
    m_drop = 0;
    sb_q.delete();
  endtask

  // One clock: drive at negedge, check handshake, advance model, check after edge
  task automatic step(input logic v, input logic [1:0] s, input logic f, input logic r);
    bit          free, emit, stall;
    logic [29:0] pd;
    logic [3:0]  pc;
    exp_frm_t    e;
    sym_valid   = v;
    sym         = s;
    flush       = f;
    frame_ready = r;
    if (frame_valid && r) begin
      chk("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("frame_data", 64'(frame_data), 64'(e.data));
        chk("frame_count", 64'(frame_count), 64'(e.cnt));
      end
    end
    stall = frame_valid && !r;
    pd    = frame_data;
    pc    = frame_count;

    free = !m_fv || r;
    emit = 0;
    if (!m_hold) begin
      if (v) begin
        m_sym[m_cnt] = s;
        m_cnt++;
      end
      if (m_cnt == 15 || (f && m_cnt > 0)) begin
        if (free) emit = 1;
        else m_hold = 1;
      end
    end else begin
      if (v) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (free) emit = 1;
    end
    if (emit) begin
      e.data = m_pack();
      e.cnt  = m_cnt;
      sb_q.push_back(e);
      m_cnt  = 0;
      m_hold = 0;
    end
    m_fv = emit || (m_fv && !r);

    @(posedge clk);
    @(negedge clk);
    chk("dct_count", 64'(dct_count), 64'(m_cnt));
    chk("dct_buffer", 64'(dct_buffer), 64'(m_pack()));
    chk("frame_valid", 64'(frame_valid), 64'(m_fv));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("idle", 64'(idle), 64'(m_cnt == 0 && !m_hold && !m_fv));
    chk("drop_count", 64'(drop_count), 64'(exp_drop()));
    if (stall) chk("frame_stable", 64'({frame_data, frame_count}), 64'({pd, pc}));
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    sym_valid   = 1'b0;
    sym         = 2'd0;
    flush       = 1'b0;
    frame_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("rst_dct_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_dct_count", 64'(dct_count), 64'd0);
    chk("rst_frame_valid", 64'(frame_valid), 64'd0);
    chk("rst_frame_data", 64'(frame_data), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    sym_valid   = 1'b0;
    sym         = 2'd0;
    flush       = 1'b0;
    frame_ready = 1'b0;
    @(negedge clk);

    // Short frame with flush, then flush on an empty buffer
    for (int i = 0; i < 5; i++)
      tbl[i] = '{v:1'b1, s:2'd3, f:1'b0, r:1'b1, exp_cnt:4'(i+1), exp_fv:1'b0, exp_data:30'h0, exp_idle:1'b0};
    tbl[5] = '{v:1'b0, s:2'd0, f:1'b1, r:1'b1, exp_cnt:4'd0, exp_fv:1'b1, exp_data:30'h3FF, exp_idle:1'b0};
    tbl[6] = '{v:1'b0, s:2'd0, f:1'b0, r:1'b1, exp_cnt:4'd0, exp_fv:1'b0, exp_data:30'h0, exp_idle:1'b1};
    tbl[7] = '{v:1'b0, s:2'd0, f:1'b1, r:1'b1, exp_cnt:4'd0, exp_fv:1'b0, exp_data:30'h0, exp_idle:1'b1};
    tbl[8] = '{v:1'b0, s:2'd0, f:1'b0, r:1'b1, exp_cnt:4'd0, exp_fv:1'b0, exp_data:30'h0, exp_idle:1'b1};

    // Full 15-symbol frame, slot i = i%4
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b1);
    chk("t1_frame_valid", 64'(frame_valid), 64'd1);
    chk("t1_frame_data", 64'(frame_data), 64'h24E4E4E4);
    chk("t1_frame_count", 64'(frame_count), 64'd15);
    chk("t1_dct_count", 64'(dct_count), 64'd0);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].f, tbl[i].r);
      chk("tbl_dct_count", 64'(dct_count), 64'(tbl[i].exp_cnt));
      chk("tbl_frame_valid", 64'(frame_valid), 64'(tbl[i].exp_fv));
      chk("tbl_idle", 64'(idle), 64'(tbl[i].exp_idle));
      if (tbl[i].exp_fv) chk("tbl_frame_data", 64'(frame_data), 64'(tbl[i].exp_data));
    end

    // Back-pressure: 35 symbols, 5 dropped
    do_reset();
    for (int i = 0; i < 35; i++) step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    chk("t3_dct_count", 64'(dct_count), 64'd15);
    chk("t3_frame_valid", 64'(frame_valid), 64'd1);
    chk("t3_state_hold", 64'(dut.state_q), 64'(HOLD));
    chk("t3_overflow", 64'(overflow), 64'd1);
`ifdef OCI_DCT_DROP_CNT_EN
    chk("t3_drop_count", 64'(drop_count), 64'd5);
`else
    chk("t3_drop_count", 64'(drop_count), 64'd0);
`endif
    step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t3_second_valid", 64'(frame_valid), 64'd1);
    chk("t3_second_count", 64'(frame_count), 64'd15);
    chk("t3_dct_count_after", 64'(dct_count), 64'd0);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Reset mid-frame discards everything
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("t5_no_frame", 64'(frame_valid), 64'd0);
    end

    // 15th symbol with flush while the held frame drains
    do_reset();
    for (int i = 0; i < 29; i++) step(1'b1, 2'((i * 3) % 4), 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 1'b1);
    chk("t6_frame_valid", 64'(frame_valid), 64'd1);
    chk("t6_frame_count", 64'(frame_count), 64'd15);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_dct_count", 64'(dct_count), 64'd0);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("t6_single_frame", 64'(frame_valid), 64'd0);

    // Symbol arriving in the HOLD transfer cycle is dropped
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b1);
    chk("hold_xfer_overflow", 64'(overflow), 64'd1);
    chk("hold_xfer_count", 64'(frame_count), 64'd4);
    step(1'b0, 2'd0, 1'b0, 1'b1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
